// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: default width, NOP encoding and
// the fetch FSM state type.
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register that catches a memory response
// arriving while the downstream output register is stalled.
module if_skid_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;

    // Flush beats load so a squashed response can never survive a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency IMEM and hands {pc, instr}
// downstream over valid/ready. Define FETCH_MISALIGN_CHK_EN to add misalign_o.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instruccion_o,
    output logic [XLEN-1:0] pc_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_o
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic            issue, resp, out_free;
    logic            skid_load, skid_unload, skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;

    assign resp     = inflight_q && !redirect_i;
    assign out_free = !out_valid_q || ready_i;
    // A response heading into the skid fills it, so hold off the next request.
    assign issue    = (state_q == RUN) && !redirect_i && !(inflight_q && !out_free);

    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (resp && !out_free) state_d = FULL;
            FULL:    if (ready_i) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (redirect_i) begin
            state_d     = RUN;
            fetch_pc_d  = {redirect_pc_i[XLEN-1:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_d = 1'b1;
                out_instr_d = skid_instr;
                out_pc_d    = skid_pc;
                skid_unload = 1'b1;
            end else if (resp) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rdata_i;
                out_pc_d    = inflight_pc_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (resp) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP_INSTR;
            out_pc_q      <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
            end
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    if_skid_buf #(
        .XLEN(XLEN)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .unload_i(skid_unload),
        .flush_i (redirect_i),
        .pc_i    (inflight_pc_q),
        .instr_i (imem_rdata_i),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign valid_o       = out_valid_q;
    assign instruccion_o = out_instr_q;
    assign pc_o          = out_pc_q;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign_q;
`else
    // Target low bits are dropped silently when the check is not built.
    logic unused_pc_low;
    assign unused_pc_low = ^redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized
// ready/redirect traffic checked against an in-order fetch-sequence model.
module tb_if_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req, valid, ready, redirect, misalign;
    logic [31:0] addr, rdata, instr, pc, redirect_pc;
    logic        req_w, valid_w, misalign_w;
    logic [31:0] addr_w, rdata_w, instr_w, pc_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h01CE_0333;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    always @(posedge clk) begin
        rdata   <= req   ? imem_word(addr)   : 32'hDEAD_BEEF;
        rdata_w <= req_w ? imem_word(addr_w) : 32'hDEAD_BEEF;
    end

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req_o(req), .imem_addr_o(addr),
        .imem_rdata_i(rdata), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready), .instruccion_o(instr), .pc_o(pc)
`ifdef FETCH_MISALIGN_CHK_EN
        , .misalign_o(misalign)
`endif
    );

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req_o(req_w), .imem_addr_o(addr_w),
        .imem_rdata_i(rdata_w), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .valid_o(valid_w), .ready_i(1'b1), .instruccion_o(instr_w), .pc_o(pc_w)
`ifdef FETCH_MISALIGN_CHK_EN
        , .misalign_o(misalign_w)
`endif
    );

`ifndef FETCH_MISALIGN_CHK_EN
    assign misalign   = 1'b0;
    assign misalign_w = 1'b0;
`endif

    // Reference model: decode must see every word from the current fetch target
    // upward, in order, exactly once; redirects restart the sequence.
    logic [31:0] exp_pc, hold_pc, hold_instr, rd_tgt, mon_nxt;
    logic        hold_flag;
    int          rd_age;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc    <= 32'h0;
            hold_flag <= 1'b0;
            rd_age    <= 0;
        end else begin
            mon_nxt = exp_pc;
            if (hold_flag) begin
                n_checks++;
                if (valid !== 1'b1 || pc !== hold_pc || instr !== hold_instr) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                             valid, pc, instr, hold_pc, hold_instr);
                end
            end
            if (rd_age == 1 || rd_age == 2) begin
                n_checks++;
                if (valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redirect_bubble: got valid=%b pc=%h expected valid=0", valid, pc);
                end
            end
            if (rd_age == 3) begin
                n_checks++;
                if (valid !== 1'b1 || pc !== rd_tgt) begin
                    n_fail++;
                    $display("FAIL redirect_target: got v=%b pc=%h expected v=1 pc=%h", valid, pc, rd_tgt);
                end
            end
            if (valid === 1'b1 && ready === 1'b1) begin
                n_checks++;
                if (pc !== exp_pc || instr !== imem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL handshake_seq: got pc=%h i=%h expected pc=%h i=%h",
                             pc, instr, exp_pc, imem_word(exp_pc));
                end
                mon_nxt = exp_pc + 32'd4;
            end
            if (redirect === 1'b1) begin
                mon_nxt = redirect_pc & 32'hFFFF_FFFC;
                rd_age  <= 1;
                rd_tgt  <= redirect_pc & 32'hFFFF_FFFC;
            end else if (rd_age > 0 && rd_age < 3) begin
                rd_age <= rd_age + 1;
            end else begin
                rd_age <= 0;
            end
            exp_pc     <= mon_nxt;
            hold_flag  <= valid && !ready && !redirect;
            hold_pc    <= pc;
            hold_instr <= instr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic test_reset();
        ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0 || instr !== NOP_INSTR || pc !== 32'h0 || req !== 1'b0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b i=%h pc=%h req=%b mis=%b expected 0/%h/0/0/0",
                     valid, instr, pc, req, misalign, NOP_INSTR);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_no_req: got req=%b v=%b expected 0/0", req, valid);
        end
        tick();
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_issue: got req=%b addr=%h v=%b expected 1/0/0", req, addr, valid);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_latency: got v=%b expected 0", valid);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h01CE_0333) begin
            n_fail++;
            $display("FAIL first_instr: got v=%b pc=%h i=%h expected 1/0/01ce0333", valid, pc, instr);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || pc !== 32'(4 * k) || instr !== imem_word(32'(4 * k))) begin
                n_fail++;
                $display("FAIL stream: got v=%b pc=%h expected v=1 pc=%h", valid, pc, 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        pulse_redirect(32'h0);
        for (int i = 0; i < 20; i++) begin
            if (valid === 1'b1 && pc === 32'h8) break;
            tick();
        end
        ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (valid !== 1'b1 || pc !== 32'h8 || req !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b pc=%h req=%b expected 1/8/0", valid, pc, req);
            end
            if (c < 2) tick();
        end
        tick();
        ready = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b pc=%h expected 1/8", valid, pc);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'hC) begin
            n_fail++;
            $display("FAIL bp_skid_out: got v=%b pc=%h expected 1/c", valid, pc);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (valid === 1'b1) break;
            tick();
        end
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h10) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b pc=%h expected 1/10", valid, pc);
        end
    endtask

    task automatic test_redirect_inflight();
        ready = 1'b1;
        pulse_redirect(32'h0);
        for (int i = 0; i < 20; i++) begin
            if (req === 1'b1 && addr === 32'h10) break;
            tick();
        end
        n_checks++;
        if (req !== 1'b1 || addr !== 32'h10) begin
            n_fail++;
            $display("FAIL wait_issue_10: got req=%b addr=%h expected 1/10", req, addr);
        end
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++;
        if (req !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_blocks_issue: got req=%b expected 0", req);
        end
        tick();
        redirect = 1'b0;
        for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL squash_bubble: got v=%b pc=%h expected v=0", valid, pc);
            end
            tick();
        end
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h100 || instr !== imem_word(32'h100)) begin
            n_fail++;
            $display("FAIL redirect_first: got v=%b pc=%h i=%h expected 1/100/%h",
                     valid, pc, instr, imem_word(32'h100));
        end
    endtask

    task automatic test_redirect_full();
        ready = 1'b1;
        pulse_redirect(32'h40);
        for (int i = 0; i < 20; i++) begin
            if (valid === 1'b1 && pc === 32'h48) break;
            tick();
        end
        ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h48 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got v=%b pc=%h req=%b expected 1/48/0", valid, pc, req);
        end
        pulse_redirect(32'h100);
        ready = 1'b1;
        #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flush: got v=%b pc=%h expected v=0", valid, pc);
        end
        tick();
        tick();
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h100) begin
            n_fail++;
            $display("FAIL full_target: got v=%b pc=%h expected 1/100", valid, pc);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h104) begin
            n_fail++;
            $display("FAIL full_target_next: got v=%b pc=%h expected 1/104", valid, pc);
        end
    endtask

    task automatic test_misalign();
        ready = 1'b1;
        pulse_redirect(32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
        n_checks++;
        if (misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_set: got %b expected 1", misalign);
        end
`endif
        tick();
`ifdef FETCH_MISALIGN_CHK_EN
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clear: got %b expected 0", misalign);
        end
`endif
        tick();
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h100) begin
            n_fail++;
            $display("FAIL misalign_pc: got v=%b pc=%h expected 1/100", valid, pc);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (valid_w === 1'b1) break;
            tick();
        end
        n_checks++;
        if (valid_w !== 1'b1 || pc_w !== 32'hFFFF_FFFC || instr_w !== imem_word(32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL wrap_first: got v=%b pc=%h expected 1/fffffffc", valid_w, pc_w);
        end
        tick();
        n_checks++;
        if (valid_w !== 1'b1 || pc_w !== 32'h0 || instr_w !== 32'h01CE_0333) begin
            n_fail++;
            $display("FAIL wrap_zero: got v=%b pc=%h i=%h expected 1/0/01ce0333", valid_w, pc_w, instr_w);
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || valid_w !== 1'b1 || pc_w !== 32'h4) begin
            n_fail++;
            $display("FAIL pre_reset_live: got v=%b vw=%b pcw=%h expected 1/1/4", valid, valid_w, pc_w);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || valid_w !== 1'b0 || instr !== NOP_INSTR || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b vw=%b i=%h pc=%h expected 0/0/%h/0",
                     valid, valid_w, instr, pc, NOP_INSTR);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (valid === 1'b1) break;
            tick();
        end
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL restart: got v=%b pc=%h expected 1/0", valid, pc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            ready       = ($urandom_range(0, 99) < 70);
            redirect    = ($urandom_range(0, 99) < 6);
            redirect_pc = $urandom();
            tick();
        end
        redirect = 1'b0;
        ready    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (valid === 1'b1) break;
            tick();
        end
        n_checks++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL random_drain_live: got v=%b expected 1", valid);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_misalign();
        test_wrap_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
